// File: rtl/shift_tx_if.sv
// Handshake and serial-line bundle between a word producer and shift_tx.
interface shift_tx_if #(
  parameter int DATA_W = 8
) ();
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              data_en;
  logic              serial_out;
  logic              busy;
  logic              ready;
  logic              done;

  modport master (
    output start, data_in, data_en,
    input  serial_out, busy, ready, done
  );

  modport slave (
    input  start, data_in, data_en,
    output serial_out, busy, ready, done
  );
endinterface

// File: rtl/shift_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first payload,
// optional even parity, stop bit. A one-deep holding buffer lets the next
// word queue up so frames can run back-to-back with no idle bit between.
module shift_tx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input logic      clk_50,
  input logic      reset,
  shift_tx_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] buf_data;
  logic              buf_full;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              parity_bit, parity_next;
  logic              serial_q, serial_next;
  logic              done_q, done_next;
  logic              take_buf;
  logic              accept;

  // A word is accepted only while the buffer is empty, so a queued word is
  // never overwritten.
  assign accept = bus.start && !buf_full;

  // Next-state, datapath and registered-output decode.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    count_next  = count;
    parity_next = parity_bit;
    done_next   = 1'b0;
    take_buf    = 1'b0;

    case (state)
      IDLE: begin
        // Buffer-to-shifter transfer does not wait for data_en.
        if (buf_full) begin
          state_next = START;
          take_buf   = 1'b1;
        end
      end
      START: begin
        if (bus.data_en) begin
          state_next = DATA;
          count_next = '0;
        end
      end
      DATA: begin
        if (bus.data_en) begin
          shift_next = shift_reg >> 1;
          if (count == LAST_BIT) begin
            state_next = PARITY_EN ? PARITY : STOP;
            count_next = '0;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bus.data_en) state_next = STOP;
      end
      STOP: begin
        if (bus.data_en) begin
          done_next = 1'b1;
          if (buf_full) begin
            state_next = START;
            take_buf   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Parity is taken from the whole word at load time because the shifter
    // is consumed bit by bit during DATA.
    if (take_buf) begin
      shift_next  = buf_data;
      parity_next = ^buf_data;
      count_next  = '0;
    end

    // The line is registered, so decode it from where the FSM is going.
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_next[0];
      PARITY:  serial_next = parity_next;
      default: serial_next = 1'b1;
    endcase
  end

  // State, datapath and holding-buffer registers with synchronous reset.
  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, which is what the decode above assumes.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= IDLE;
      buf_data   <= '0;
      buf_full   <= 1'b0;
      shift_reg  <= '0;
      count      <= '0;
      parity_bit <= 1'b0;
      serial_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      count      <= count_next;
      parity_bit <= parity_next;
      serial_q   <= serial_next;
      done_q     <= done_next;
      if (take_buf) begin
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_full <= 1'b1;
        buf_data <= bus.data_in;
      end
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.busy       = (state != IDLE);
  assign bus.ready      = !buf_full;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_shift_tx.sv
// Directed bench for shift_tx: one parity-enabled instance and one
// parity-disabled instance sharing clock and reset.
module tb_shift_tx;

  logic clk_50;
  logic reset;
  int   n_checks;
  int   n_fail;

  shift_tx_if #(.DATA_W(8)) bp ();
  shift_tx_if #(.DATA_W(8)) bn ();

  shift_tx #(.DATA_W(8), .PARITY_EN(1'b1)) dut_p (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bp)
  );

  shift_tx #(.DATA_W(8), .PARITY_EN(1'b0)) dut_n (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bn)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  // Advance one rising edge and settle just past it before sampling.
  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bp.start   = 1'b1;
    bp.data_in = 8'hFF;
    bp.data_en = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bp.serial_out !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b expected 1", bp.serial_out); end
    n_checks++;
    if (bp.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bp.busy); end
    n_checks++;
    if (bp.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bp.ready); end
    n_checks++;
    if (bp.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bp.done); end
    n_checks++;
    if (bn.serial_out !== 1'b1) begin n_fail++; $display("FAIL reset_serial_np: got %b expected 1", bn.serial_out); end
    reset      = 1'b0;
    bp.start   = 1'b0;
    bp.data_en = 1'b0;
    tick();
    // start was high on reset edges only, so nothing may have been queued.
    n_checks++;
    if (bp.ready !== 1'b1 || bp.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_override: ready=%b busy=%b expected ready=1 busy=0", bp.ready, bp.busy);
    end
  endtask

  task automatic test_single_frame();
    logic exp_bits [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bp.data_in = 8'hA5;
    bp.start   = 1'b1;
    bp.data_en = 1'b1;
    tick();  // E0
    bp.start = 1'b0;
    n_checks++;
    if (bp.ready !== 1'b0 || bp.serial_out !== 1'b1 || bp.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_accept: ready=%b serial=%b busy=%b expected 0 1 0", bp.ready, bp.serial_out, bp.busy);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_checks++;
      if (bp.serial_out !== exp_bits[k-1] || bp.done !== 1'b0) begin
        n_fail++; $display("FAIL single_bit k=%0d: serial=%b done=%b expected %b 0", k, bp.serial_out, bp.done, exp_bits[k-1]);
      end
      if (k == 1) begin
        n_checks++;
        if (bp.busy !== 1'b1 || bp.ready !== 1'b1) begin
          n_fail++; $display("FAIL single_start: busy=%b ready=%b expected 1 1", bp.busy, bp.ready);
        end
      end
    end
    tick();  // E12
    n_checks++;
    if (bp.done !== 1'b1 || bp.serial_out !== 1'b1 || bp.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: done=%b serial=%b busy=%b expected 1 1 0", bp.done, bp.serial_out, bp.busy);
    end
    tick();
    n_checks++;
    if (bp.done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0", bp.done); end
  endtask

  task automatic test_back_to_back();
    logic exp_bits [22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                            1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic exp_s;
    logic exp_d;
    int   done_cnt;
    done_cnt   = 0;
    bp.data_in = 8'h01;
    bp.start   = 1'b1;
    bp.data_en = 1'b1;
    tick();  // E0
    bp.start = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      if (k == 2) begin
        bp.start   = 1'b1;
        bp.data_in = 8'hFF;
      end else if (k >= 3 && k <= 11) begin
        // Buffer is full: these requests must all be ignored.
        bp.start   = 1'b1;
        bp.data_in = 8'h55;
      end else if (k == 12) begin
        bp.start = 1'b0;
      end
      tick();
      exp_s = (k <= 22) ? exp_bits[k-1] : 1'b1;
      exp_d = (k == 12 || k == 23);
      if (bp.done === 1'b1) done_cnt++;
      n_checks++;
      if (bp.serial_out !== exp_s || bp.done !== exp_d) begin
        n_fail++; $display("FAIL b2b k=%0d: serial=%b done=%b expected %b %b", k, bp.serial_out, bp.done, exp_s, exp_d);
      end
      if (k == 2 || k == 12) begin
        n_checks++;
        if (bp.ready !== (k == 12)) begin
          n_fail++; $display("FAIL b2b_ready k=%0d: got %b expected %b", k, bp.ready, (k == 12));
        end
      end
    end
    n_checks++;
    if (done_cnt != 2 || bp.busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_frames: done_count=%0d busy=%b expected 2 0", done_cnt, bp.busy);
    end
  endtask

  task automatic test_data_en_gate();
    logic exp_bits [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_s;
    logic exp_d;
    logic exp_b;
    bp.data_in = 8'h3C;
    bp.start   = 1'b1;
    bp.data_en = 1'b0;
    tick();  // E0
    bp.start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      bp.data_en = (k % 2 == 1);
      tick();
      exp_s = (k <= 22) ? exp_bits[(k-1)/2] : 1'b1;
      exp_d = (k == 23);
      exp_b = (k <= 22);
      n_checks++;
      if (bp.serial_out !== exp_s || bp.done !== exp_d || bp.busy !== exp_b) begin
        n_fail++; $display("FAIL gate k=%0d: serial=%b done=%b busy=%b expected %b %b %b",
                           k, bp.serial_out, bp.done, bp.busy, exp_s, exp_d, exp_b);
      end
    end
    bp.data_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    bp.data_in = 8'hA5;
    bp.start   = 1'b1;
    bp.data_en = 1'b1;
    tick();  // E0
    bp.start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) begin
        bp.start   = 1'b1;
        bp.data_in = 8'h0F;
      end else begin
        bp.start = 1'b0;
      end
      tick();
    end
    // Sending data bit 4 of 8'hA5 with 8'h0F queued.
    n_checks++;
    if (bp.serial_out !== 1'b0 || bp.ready !== 1'b0 || bp.busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_bit4: serial=%b ready=%b busy=%b expected 0 0 1", bp.serial_out, bp.ready, bp.busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (bp.serial_out !== 1'b1 || bp.busy !== 1'b0 || bp.ready !== 1'b1 || bp.done !== 1'b0) begin
      n_fail++; $display("FAIL mid_abort: serial=%b busy=%b ready=%b done=%b expected 1 0 1 0",
                         bp.serial_out, bp.busy, bp.ready, bp.done);
    end
    for (int k = 0; k < 14; k++) begin
      tick();
      n_checks++;
      if (bp.serial_out !== 1'b1 || bp.busy !== 1'b0 || bp.done !== 1'b0) begin
        n_fail++; $display("FAIL mid_quiet k=%0d: serial=%b busy=%b done=%b expected 1 0 0",
                           k, bp.serial_out, bp.busy, bp.done);
      end
    end
  endtask

  task automatic test_no_parity();
    logic exp_bits [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bn.data_in = 8'h80;
    bn.start   = 1'b1;
    bn.data_en = 1'b1;
    tick();  // E0
    bn.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (bn.serial_out !== exp_bits[k-1] || bn.done !== 1'b0) begin
        n_fail++; $display("FAIL np_bit k=%0d: serial=%b done=%b expected %b 0", k, bn.serial_out, bn.done, exp_bits[k-1]);
      end
    end
    tick();  // E11
    n_checks++;
    if (bn.done !== 1'b1 || bn.serial_out !== 1'b1 || bn.busy !== 1'b0) begin
      n_fail++; $display("FAIL np_done: done=%b serial=%b busy=%b expected 1 1 0", bn.done, bn.serial_out, bn.busy);
    end
    tick();
    n_checks++;
    if (bn.done !== 1'b0) begin n_fail++; $display("FAIL np_done_pulse: got %b expected 0", bn.done); end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bp.start   = 1'b0;
    bp.data_in = '0;
    bp.data_en = 1'b0;
    bn.start   = 1'b0;
    bn.data_in = '0;
    bn.data_en = 1'b0;

    test_reset();
    test_single_frame();
    tick();
    test_back_to_back();
    tick();
    test_data_en_gate();
    tick();
    test_reset_mid_frame();
    test_no_parity();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_tx.md
SHIFT_TX -- requirements
Module: shift_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame.
REQ-002 Parameter PARITY_EN, default 1: 1 = even parity bit appended after data, 0 = no parity bit.
REQ-003 clk_50  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  load request; accepted on an edge where start=1 and ready=1.
REQ-006 data_in  input  DATA_W  parallel word captured on accept.
REQ-007 data_en  input  1  bit-advance enable; frame advances only on edges where data_en=1.
REQ-008 serial_out  output  1  serial line, idle high, registered.
REQ-009 busy  output  1  high while a frame is in progress (state != IDLE).
REQ-010 ready  output  1  high when holding buffer is empty.
REQ-011 done  output  1  one-cycle pulse after a frame's stop bit completes.

Function
REQ-012 Datapath: one-deep holding buffer, shift register of DATA_W bits, bit counter, running parity, state register.
REQ-013 States: IDLE, START, DATA, PARITY, STOP.
REQ-014 Accept: start=1 and ready=1 at an edge loads data_in into buffer; ready=0 from the next cycle.
REQ-015 start while ready=0 is ignored; buffer contents are never overwritten.
REQ-016 IDLE with buffer full: next edge -> START, buffer moves to shift register, buffer empties (ready=1). This transfer is independent of data_en.
REQ-017 START: serial_out=0; on a data_en edge -> DATA, count=0.
REQ-018 DATA: serial_out = shift register bit 0 (LSB first); each data_en edge shifts right and increments count; after bit DATA_W-1 -> PARITY (PARITY_EN=1) or STOP.
REQ-019 PARITY: serial_out = XOR of all DATA_W payload bits (even parity); on a data_en edge -> STOP.
REQ-020 STOP: serial_out=1; on a data_en edge, done=1 for the following cycle only; next state START if buffer full (back-to-back, no idle bit), else IDLE.
REQ-021 data_en=0: state, count, shift register and serial_out hold; buffer accept (REQ-014) still operates.
REQ-022 IDLE: serial_out=1.
REQ-023 Latency with data_en=1 throughout: accept at edge E0 -> START after E1 -> DATA bit0 after E2 -> PARITY after E10 -> STOP after E11 -> done high in cycle after E12.
REQ-024 Frame length in data_en-qualified bit periods: 1 + DATA_W + PARITY_EN + 1.
REQ-025 Buffer full on the STOP-exit edge is loaded into the shift register on that same edge; buffer empties, ready=1 the next cycle.

Reset
REQ-026 reset=1 at an edge: state=IDLE, serial_out=1, busy=0, ready=1, done=0, buffer empty, count=0, shift register=0.
REQ-027 reset overrides start and data_en on the same edge.
REQ-028 reset mid-frame aborts the frame: line high the next cycle, no done pulse, buffered word discarded.

Verification
REQ-029 After reset, data_in=8'hA5, 1-cycle start, data_en=1 -> serial_out 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop); done pulses once, in the cycle after E12.
REQ-030 Accept 8'h01, then accept 8'hFF while busy -> frame 2 start bit immediately follows frame 1 stop bit; parity 1 then 0; two done pulses 11 cycles apart.
REQ-031 data_en alternating 1/0 during frame of 8'h3C -> each bit held 2 cycles, frame 22 cycles, bit order unchanged.
REQ-032 Third start while ready=0 (buffer full, frame active) -> ignored; exactly two frames transmitted, two done pulses.
REQ-033 reset asserted while sending DATA bit 4 -> next cycle serial_out=1, busy=0, ready=1; no done.
REQ-034 PARITY_EN=0, data_in=8'h80 -> serial_out 0,0,0,0,0,0,0,0,1,1 (10 bits); done in the cycle after E11.
